// File: rtl/cc_branch_ctrl.sv
// Comparison-code sequencer: launches an ALU compare, waits with a timeout,
// writes or clears the comparison-code register and resolves branches.
module cc_branch_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       alu_done,
  input  logic [1:0] alu_code,
  input  logic [1:0] cc_value,
  output logic       alu_start,
  output logic [1:0] cc_data,
  output logic       cc_w,
  output logic       cc_clear,
  output logic       pc_load,
  output logic       busy,
  output logic       done,
  output logic       taken,
  output logic       err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_ALU = 3'd2,
    WRITE_CC = 3'd3,
    EVAL     = 3'd4,
    CLEAR    = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [1:0] OP_CMP    = 2'b00;
  localparam logic [1:0] OP_BR     = 2'b01;
  localparam logic [1:0] OP_CMP_BR = 2'b10;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic [1:0] op_q;
  logic [2:0] cond_q;
  logic [1:0] code_q;
  logic [7:0] count;
  logic [7:0] count_next;
  logic [1:0] eval_code;
  logic       eval_taken;

  // Handshakes: start is a one-cycle request honoured only while busy is low
  // (otherwise dropped); alu_start launches one compare, and alu_done with
  // alu_code is taken only in WAIT_ALU, so early or stray completions are ignored.
  always_comb begin
    count_next = count + 8'd1;
    eval_code  = (op_q == OP_CMP_BR) ? code_q : cc_value;
    eval_taken = 1'b0;
    case (eval_code)
      2'b00:   eval_taken = cond_q[0];
      2'b01:   eval_taken = cond_q[1];
      2'b10:   eval_taken = cond_q[2];
      default: eval_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      cond_q    <= 3'b000;
      code_q    <= 2'b00;
      count     <= 8'd0;
      alu_start <= 1'b0;
      cc_data   <= 2'b00;
      cc_w      <= 1'b0;
      cc_clear  <= 1'b0;
      pc_load   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      taken     <= 1'b0;
      err       <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      cc_w      <= 1'b0;
      cc_clear  <= 1'b0;
      pc_load   <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            cond_q <= cond;
            taken  <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b1;
            case (op)
              OP_CMP, OP_CMP_BR: begin
                state     <= LAUNCH;
                alu_start <= 1'b1;
              end
              OP_BR: state <= EVAL;
              default: begin
                state    <= CLEAR;
                cc_clear <= 1'b1;
              end
            endcase
          end
        end
        LAUNCH: begin
          count <= 8'd0;
          state <= WAIT_ALU;
        end
        WAIT_ALU: begin
          // A completion arriving on the timeout cycle still wins.
          if (alu_done) begin
            code_q  <= alu_code;
            cc_data <= alu_code;
            cc_w    <= 1'b1;
            if (alu_code == 2'b11) err <= 1'b1;
            state   <= WRITE_CC;
          end else if (count_next == TIMEOUT_CNT) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            count <= count_next;
          end
        end
        WRITE_CC: begin
          if (op_q == OP_CMP_BR) begin
            state <= EVAL;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        EVAL: begin
          taken   <= eval_taken;
          pc_load <= eval_taken;
          if (eval_code == 2'b11) err <= 1'b1;
          done    <= 1'b1;
          state   <= DONE;
        end
        CLEAR: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Debug view of the state; 0 means IDLE.
  assign state_dbg = state;

endmodule

// File: tb/tb_cc_branch_ctrl.sv
// Bench for cc_branch_ctrl: reset checks, a vector table, hand sequences for
// multi-cycle corners, and random transactions against a cycle-schedule model.
module tb_cc_branch_ctrl;
  localparam int TO  = 4;
  localparam int WIN = TO + 6;
  localparam int NV  = 14;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [2:0] cond;
  logic       alu_done;
  logic [1:0] alu_code;
  logic [1:0] cc_value;
  logic       alu_start;
  logic [1:0] cc_data;
  logic       cc_w;
  logic       cc_clear;
  logic       pc_load;
  logic       busy;
  logic       done;
  logic       taken;
  logic       err;
  logic [2:0] state_dbg;
  logic [12:0] out_vec;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] last_cc;

  typedef struct {
    int as_cyc;  int as_cnt;
    int ccw_cyc; int ccw_cnt;
    int clr_cyc; int clr_cnt;
    int done_cyc; int done_last; int done_cnt;
    int pcl_cyc; int pcl_cnt;
    int busy_cnt; int busy_last;
    int taken_d; int err_d;
    int taken_end; int err_end; int ccdata_end;
  } obs_t;

  typedef struct {
    logic [1:0] op; logic [2:0] cond; logic [1:0] ccv; int d; logic [1:0] code;
    int exp_done; int exp_taken; int exp_err; int exp_ccw_cyc;
  } vec_t;

  vec_t vecs[NV];

  cc_branch_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .reset(reset), .start(start), .op(op), .cond(cond),
    .alu_done(alu_done), .alu_code(alu_code), .cc_value(cc_value),
    .alu_start(alu_start), .cc_data(cc_data), .cc_w(cc_w), .cc_clear(cc_clear),
    .pc_load(pc_load), .busy(busy), .done(done), .taken(taken), .err(err),
    .state_dbg(state_dbg)
  );

  assign out_vec = {alu_start, cc_data, cc_w, cc_clear, pc_load, busy, done, taken, err, state_dbg};

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Expected schedule from the operation rules, counted from the start cycle.
  function automatic obs_t model(input logic [1:0] op_i, input logic [2:0] cond_i,
                                 input logic [1:0] ccv_i, input int d_i,
                                 input logic [1:0] code_i, input logic [1:0] prev);
    obs_t e;
    int ev;
    int tk;
    e = '{default: 0};
    ev = -1;
    tk = 0;
    e.ccdata_end = int'(prev);
    if (op_i == 2'b00 || op_i == 2'b10) begin
      e.as_cyc = 1; e.as_cnt = 1;
      if (d_i < TO) begin
        e.ccw_cyc = 3 + d_i; e.ccw_cnt = 1;
        e.ccdata_end = int'(code_i);
        e.err_d = (code_i == 2'b11) ? 1 : 0;
        if (op_i == 2'b10) begin
          e.done_cyc = 5 + d_i;
          ev = int'(code_i);
        end else begin
          e.done_cyc = 4 + d_i;
        end
      end else begin
        e.done_cyc = 2 + TO;
        e.err_d = 1;
      end
    end else if (op_i == 2'b01) begin
      e.done_cyc = 2;
      ev = int'(ccv_i);
    end else begin
      e.clr_cyc = 1; e.clr_cnt = 1;
      e.done_cyc = 2;
    end
    if (ev == 3) e.err_d = 1;
    else if (ev >= 0) tk = int'(cond_i[ev]);
    e.taken_d = tk;
    e.done_last = e.done_cyc;
    e.done_cnt = 1;
    e.pcl_cnt = tk;
    e.pcl_cyc = (tk != 0) ? e.done_cyc : 0;
    e.busy_cnt = e.done_cyc;
    e.busy_last = e.done_cyc;
    e.taken_end = e.taken_d;
    e.err_end = e.err_d;
    return e;
  endfunction

  // Caller is just after a rising edge; that cycle is cycle 0 and carries start.
  task automatic run_txn(input logic [1:0] op_i, input logic [2:0] cond_i,
                         input logic [1:0] ccv_i, input int d_i, input logic [1:0] code_i,
                         input int unsigned start_mask, input bit noise, output obs_t o);
    bit cmp_op;
    int quiet_end;
    o = '{default: 0};
    cmp_op = (op_i == 2'b00) || (op_i == 2'b10);
    quiet_end = (d_i < TO) ? 2 + d_i : TO + 1;
    start = 1'b1; op = op_i; cond = cond_i; cc_value = ccv_i;
    alu_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    alu_code = 2'($urandom_range(0, 3));
    for (int n = 1; n <= WIN; n++) begin
      @(posedge CLK); #1;
      if (alu_start) begin o.as_cnt++; if (o.as_cyc == 0) o.as_cyc = n; end
      if (cc_w) begin
        o.ccw_cnt++; if (o.ccw_cyc == 0) o.ccw_cyc = n;
        if (exp_q.size() > 0) check("cc_data_write", int'(cc_data), int'(exp_q.pop_front()));
        else check("cc_w_unexpected", int'(cc_w), 0);
      end
      if (cc_clear) begin o.clr_cnt++; if (o.clr_cyc == 0) o.clr_cyc = n; end
      if (done) begin
        o.done_cnt++; if (o.done_cyc == 0) o.done_cyc = n;
        o.done_last = n; o.taken_d = int'(taken); o.err_d = int'(err);
      end
      if (pc_load) begin o.pcl_cnt++; if (o.pcl_cyc == 0) o.pcl_cyc = n; end
      if (busy) begin o.busy_cnt++; o.busy_last = n; end
      start = start_mask[n];
      if (cmp_op && n >= 2 && n <= quiet_end) begin
        alu_done = (n == 2 + d_i) && (d_i < TO);
        alu_code = alu_done ? code_i : 2'($urandom_range(0, 3));
      end else begin
        alu_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        alu_code = 2'($urandom_range(0, 3));
      end
    end
    o.taken_end = int'(taken);
    o.err_end = int'(err);
    o.ccdata_end = int'(cc_data);
    start = 1'b0;
    alu_done = 1'b0;
  endtask

  task automatic compare_obs(input string tag, input obs_t o, input obs_t e);
    check({tag, "_alu_start_cyc"}, o.as_cyc, e.as_cyc);
    check({tag, "_alu_start_cnt"}, o.as_cnt, e.as_cnt);
    check({tag, "_cc_w_cyc"}, o.ccw_cyc, e.ccw_cyc);
    check({tag, "_cc_w_cnt"}, o.ccw_cnt, e.ccw_cnt);
    check({tag, "_cc_clear_cyc"}, o.clr_cyc, e.clr_cyc);
    check({tag, "_cc_clear_cnt"}, o.clr_cnt, e.clr_cnt);
    check({tag, "_done_cyc"}, o.done_cyc, e.done_cyc);
    check({tag, "_done_cnt"}, o.done_cnt, e.done_cnt);
    check({tag, "_pc_load_cyc"}, o.pcl_cyc, e.pcl_cyc);
    check({tag, "_pc_load_cnt"}, o.pcl_cnt, e.pcl_cnt);
    check({tag, "_busy_cnt"}, o.busy_cnt, e.busy_cnt);
    check({tag, "_busy_last"}, o.busy_last, e.busy_last);
    check({tag, "_taken"}, o.taken_d, e.taken_d);
    check({tag, "_err"}, o.err_d, e.err_d);
    check({tag, "_taken_held"}, o.taken_end, e.taken_end);
    check({tag, "_err_held"}, o.err_end, e.err_end);
    check({tag, "_cc_data_held"}, o.ccdata_end, e.ccdata_end);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    obs_t o;
    obs_t e;
    vec_t v;
    int unsigned mask;
    logic [1:0] r_op; logic [2:0] r_cond; logic [1:0] r_ccv; logic [1:0] r_code; int r_d;

    //            op     cond    ccv   d   code  done tk er ccw
    vecs[0]  = '{2'b10, 3'b010, 2'b00, 0, 2'b01, 5, 1, 0, 3};
    vecs[1]  = '{2'b01, 3'b011, 2'b10, 0, 2'b00, 2, 0, 0, 0};
    vecs[2]  = '{2'b01, 3'b011, 2'b11, 0, 2'b00, 2, 0, 1, 0};
    vecs[3]  = '{2'b00, 3'b000, 2'b00, 4, 2'b00, 6, 0, 1, 0};
    vecs[4]  = '{2'b11, 3'b111, 2'b00, 0, 2'b00, 2, 0, 0, 0};
    vecs[5]  = '{2'b00, 3'b111, 2'b00, 0, 2'b00, 4, 0, 0, 3};
    vecs[6]  = '{2'b00, 3'b111, 2'b00, 2, 2'b11, 6, 0, 1, 5};
    vecs[7]  = '{2'b10, 3'b111, 2'b00, 1, 2'b10, 6, 1, 0, 4};
    vecs[8]  = '{2'b10, 3'b000, 2'b00, 0, 2'b00, 5, 0, 0, 3};
    vecs[9]  = '{2'b10, 3'b111, 2'b00, 0, 2'b11, 5, 0, 1, 3};
    vecs[10] = '{2'b10, 3'b100, 2'b00, 3, 2'b10, 8, 1, 0, 6};
    vecs[11] = '{2'b10, 3'b111, 2'b00, 4, 2'b01, 6, 0, 1, 0};
    vecs[12] = '{2'b01, 3'b001, 2'b00, 0, 2'b00, 2, 1, 0, 0};
    vecs[13] = '{2'b01, 3'b101, 2'b01, 0, 2'b00, 2, 0, 0, 0};

    // Reset held with random inputs, then quiet release.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom_range(0, 1)); op = 2'($urandom_range(0, 3));
      cond = 3'($urandom_range(0, 7)); alu_done = 1'($urandom_range(0, 1));
      alu_code = 2'($urandom_range(0, 3)); cc_value = 2'($urandom_range(0, 3));
      @(negedge CLK);
      check("reset_held_outputs", int'(out_vec), 0);
    end
    start = 1'b0; op = 2'b00; cond = 3'b000; alu_done = 1'b0; alu_code = 2'b00; cc_value = 2'b00;
    @(negedge CLK);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("post_reset_outputs", int'(out_vec), 0);
    end
    last_cc = 2'b00;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      if (v.exp_ccw_cyc != 0) begin
        exp_q.push_back(v.code);
        last_cc = v.code;
      end
      run_txn(v.op, v.cond, v.ccv, v.d, v.code, 32'd0, 1'b0, o);
      check($sformatf("vec%0d_done_cyc", i), o.done_cyc, v.exp_done);
      check($sformatf("vec%0d_done_cnt", i), o.done_cnt, 1);
      check($sformatf("vec%0d_taken", i), o.taken_d, v.exp_taken);
      check($sformatf("vec%0d_err", i), o.err_d, v.exp_err);
      check($sformatf("vec%0d_pc_load_cnt", i), o.pcl_cnt, v.exp_taken);
      check($sformatf("vec%0d_cc_w_cyc", i), o.ccw_cyc, v.exp_ccw_cyc);
      check($sformatf("vec%0d_cc_w_cnt", i), o.ccw_cnt, (v.exp_ccw_cyc != 0) ? 1 : 0);
      check($sformatf("vec%0d_busy_last", i), o.busy_last, v.exp_done);
      check($sformatf("vec%0d_busy_cnt", i), o.busy_cnt, v.exp_done);
      check($sformatf("vec%0d_taken_held", i), o.taken_end, v.exp_taken);
      check($sformatf("vec%0d_err_held", i), o.err_end, v.exp_err);
      check($sformatf("vec%0d_cc_data_held", i), o.ccdata_end, int'(last_cc));
      check($sformatf("vec%0d_missing_cc_w", i), exp_q.size(), 0);
      exp_q.delete();
    end

    // CLR with start re-asserted in cycles 1 and 2: only one operation.
    run_txn(2'b11, 3'b000, 2'b00, 0, 2'b00, 32'h6, 1'b0, o);
    check("clr_cc_clear_cyc", o.clr_cyc, 1);
    check("clr_cc_clear_cnt", o.clr_cnt, 1);
    check("clr_done_cyc", o.done_cyc, 2);
    check("clr_done_cnt", o.done_cnt, 1);
    check("clr_busy_last", o.busy_last, 2);

    // Back-to-back BR: second start in the first IDLE cycle after DONE.
    run_txn(2'b01, 3'b001, 2'b00, 0, 2'b00, 32'h8, 1'b0, o);
    check("b2b_done_cnt", o.done_cnt, 2);
    check("b2b_first_done", o.done_cyc, 2);
    check("b2b_second_done", o.done_last, 5);
    check("b2b_pc_load_cnt", o.pcl_cnt, 2);
    check("b2b_busy_cnt", o.busy_cnt, 4);

    // Random transactions with start and alu_done noise where it must be ignored.
    for (int t = 0; t < 80; t++) begin
      r_op = 2'($urandom_range(0, 3)); r_cond = 3'($urandom_range(0, 7));
      r_ccv = 2'($urandom_range(0, 3)); r_code = 2'($urandom_range(0, 3));
      r_d = $urandom_range(0, TO);
      e = model(r_op, r_cond, r_ccv, r_d, r_code, last_cc);
      if (e.ccw_cnt != 0) exp_q.push_back(r_code);
      mask = $urandom & ((32'd1 << (e.done_cyc + 1)) - 32'd2);
      run_txn(r_op, r_cond, r_ccv, r_d, r_code, mask, 1'b1, o);
      compare_obs($sformatf("rnd%0d", t), o, e);
      check($sformatf("rnd%0d_missing_cc_w", t), exp_q.size(), 0);
      exp_q.delete();
      last_cc = 2'(e.ccdata_end);
    end

    // Reset asserted in WAIT_ALU, then a late alu_done after release.
    start = 1'b1; op = 2'b00; cond = 3'b111; cc_value = 2'b00;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("busy_in_wait", int'(busy), 1);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", int'(out_vec), 0);
    @(negedge CLK);
    reset = 1'b1;
    alu_done = 1'b1;
    alu_code = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("late_alu_done_outputs", int'(out_vec), 0);
    end
    alu_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
